mem_port_arbiter: RTL and testbench

//  Shares the single memory port between the icache (fetch) and the dcache (ex_stage) behind the R10K core top.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between the icache (fetch) and the dcache
//   (ex_stage). The dcache normally wins a conflict. After STARVE_LIMIT
//   consecutive icache losses, the icache is forced to win. The block records
//   which client owns each outstanding load tag and routes each returning
//   tag/data pair only to that owner.
// Ports
//   clock, reset               system clock, synchronous active-high reset
//   ic_command/ic_addr         icache request (NONE or LOAD)
//   dc_command/dc_addr/dc_data dcache request (NONE, LOAD or STORE)
//   mem2proc_response          same-cycle acceptance tag (0 = rejected)
//   mem2proc_data/mem2proc_tag returning data and its tag (0 = none)
//   proc2mem_command/addr/data command, address and store data sent to memory
//   ic_grant/dc_grant          the client's request is on the bus this cycle
//   ic_response/dc_response    acceptance tag, gated by the client's grant
//   ic_tag/dc_tag              return tag, gated by ownership
//   ic_data/dc_data_out        returning data (qualified by *_tag)
//   outstanding                number of valid owner-table entries (registered)
//   orphan_err                 sticky: unowned return or overwritten live tag
module mem_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned TAG_BITS     = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          ic_command,
  input  logic [XLEN-1:0]     ic_addr,
  input  logic [1:0]          dc_command,
  input  logic [XLEN-1:0]     dc_addr,
  input  logic [63:0]         dc_data,
  input  logic [TAG_BITS-1:0] mem2proc_response,
  input  logic [63:0]         mem2proc_data,
  input  logic [TAG_BITS-1:0] mem2proc_tag,
  output logic [1:0]          proc2mem_command,
  output logic [XLEN-1:0]     proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  output logic                ic_grant,
  output logic                dc_grant,
  output logic [TAG_BITS-1:0] ic_response,
  output logic [TAG_BITS-1:0] dc_response,
  output logic [TAG_BITS-1:0] ic_tag,
  output logic [TAG_BITS-1:0] dc_tag,
  output logic [63:0]         ic_data,
  output logic [63:0]         dc_data_out,
  output logic [TAG_BITS:0]   outstanding,
  output logic                orphan_err
);

  localparam int unsigned NUM = 1 << TAG_BITS;
  localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CW  = TAG_BITS + 1;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  logic [NUM-1:0] valid_q, valid_d;
  logic [NUM-1:0] owner_q, owner_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [CW-1:0]  outstanding_d;
  logic           orphan_d;

  logic ic_req, dc_req, starved;
  logic accept, accept_owner, ret_hit, ret_owner, overwrite;

  function automatic logic [CW-1:0] popcount(input logic [NUM-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Arbitration and request mux
  always_comb begin
    ic_req  = (ic_command != BUS_NONE);
    dc_req  = (dc_command != BUS_NONE);
    starved = (starve_q == SW'(STARVE_LIMIT));

    ic_grant = ic_req && (!dc_req || starved);
    dc_grant = dc_req && !ic_grant;

    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    if (ic_grant) begin
      proc2mem_command = ic_command;
      proc2mem_addr    = ic_addr;
    end else if (dc_grant) begin
      proc2mem_command = dc_command;
      proc2mem_addr    = dc_addr;
    end
    proc2mem_data = dc_data;

    ic_response = ic_grant ? mem2proc_response : '0;
    dc_response = dc_grant ? mem2proc_response : '0;
  end

  // Return routing by recorded owner
  always_comb begin
    ret_hit   = (mem2proc_tag != '0) && valid_q[mem2proc_tag];
    ret_owner = owner_q[mem2proc_tag];
    ic_tag    = (ret_hit && ret_owner == OWNER_IC) ? mem2proc_tag : '0;
    dc_tag    = (ret_hit && ret_owner == OWNER_DC) ? mem2proc_tag : '0;
    ic_data     = mem2proc_data;
    dc_data_out = mem2proc_data;
  end

  // Owner-table, starvation counter and error next-state
  always_comb begin
    accept = (mem2proc_response != '0) &&
             ((ic_grant && ic_command == BUS_LOAD) ||
              (dc_grant && dc_command == BUS_LOAD));
    accept_owner = dc_grant ? OWNER_DC : OWNER_IC;

    valid_d = valid_q;
    owner_d = owner_q;
    // Return clears first so a same-cycle re-accept of that tag survives.
    if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
    if (accept) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = accept_owner;
    end
    outstanding_d = popcount(valid_d);

    // A live tag being re-issued is only legal if it is returning this cycle.
    overwrite = accept && valid_q[mem2proc_response] &&
                !(ret_hit && mem2proc_tag == mem2proc_response);
    orphan_d  = orphan_err || overwrite ||
                ((mem2proc_tag != '0) && !valid_q[mem2proc_tag]);

    starve_d = starve_q;
    if (ic_req && !ic_grant) begin
      if (!starved) starve_d = starve_q + SW'(1);
    end else if (ic_grant && mem2proc_response != '0) begin
      starve_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= '0;
      owner_q     <= '0;
      starve_q    <= '0;
      outstanding <= '0;
      orphan_err  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      outstanding <= outstanding_d;
      orphan_err  <= orphan_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: grant/response gating, starvation
//   override, owner-tagged return routing, stores, rejects and reset.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ic_command, dc_command;
  logic [31:0] ic_addr, dc_addr;
  logic [63:0] dc_data, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic        ic_grant, dc_grant;
  logic [3:0]  ic_response, dc_response, ic_tag, dc_tag;
  logic [63:0] ic_data, dc_data_out;
  logic [4:0]  outstanding;
  logic        orphan_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_command(ic_command), .ic_addr(ic_addr),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .ic_grant(ic_grant), .dc_grant(dc_grant),
    .ic_response(ic_response), .dc_response(dc_response),
    .ic_tag(ic_tag), .dc_tag(dc_tag),
    .ic_data(ic_data), .dc_data_out(dc_data_out),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ic_command = 2'd0; ic_addr = '0;
    dc_command = 2'd0; dc_addr = '0; dc_data = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    #1;
    check("rst_cmd", 64'(proc2mem_command), 64'd0);
    check("rst_grants", 64'({ic_grant, dc_grant}), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_orphan", 64'(orphan_err), 64'd0);
    check("rst_addr", 64'(proc2mem_addr), 64'd0);
    reset = 1'b0;
    tick();

    // 1: single icache load, then its return
    ic_command = 2'd1; ic_addr = 32'h100; mem2proc_response = 4'd3;
    #1;
    check("t1_ic_grant", 64'(ic_grant), 64'd1);
    check("t1_dc_grant", 64'(dc_grant), 64'd0);
    check("t1_ic_resp", 64'(ic_response), 64'd3);
    check("t1_dc_resp", 64'(dc_response), 64'd0);
    check("t1_cmd", 64'(proc2mem_command), 64'd1);
    check("t1_addr", 64'(proc2mem_addr), 64'h100);
    tick(); idle(); #1;
    check("t1_outstanding1", 64'(outstanding), 64'd1);
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0000_0003; #1;
    check("t1_ic_tag", 64'(ic_tag), 64'd3);
    check("t1_dc_tag", 64'(dc_tag), 64'd0);
    check("t1_ic_data", ic_data, 64'hDEAD_BEEF_0000_0003);
    tick(); idle(); #1;
    check("t1_outstanding0", 64'(outstanding), 64'd0);

    // 2: both load every cycle; icache forced on the 5th conflict
    for (int k = 0; k < 6; k++) begin
      ic_command = 2'd1; ic_addr = 32'h1000 + 32'(k);
      dc_command = 2'd1; dc_addr = 32'h2000 + 32'(k);
      mem2proc_response = 4'(k + 1);
      #1;
      check($sformatf("t2_ic_grant_%0d", k), 64'(ic_grant), 64'(k == 4));
      check($sformatf("t2_dc_grant_%0d", k), 64'(dc_grant), 64'(k != 4));
      check($sformatf("t2_addr_%0d", k), 64'(proc2mem_addr),
            (k == 4) ? 64'h1004 : 64'h2000 + 64'(k));
      tick();
    end
    idle(); #1;
    check("t2_outstanding6", 64'(outstanding), 64'd6);
    for (int t = 1; t <= 6; t++) begin
      mem2proc_tag = 4'(t); mem2proc_data = 64'(t) << 8; #1;
      check($sformatf("t2_ic_tag_%0d", t), 64'(ic_tag), (t == 5) ? 64'(t) : 64'd0);
      check($sformatf("t2_dc_tag_%0d", t), 64'(dc_tag), (t == 5) ? 64'd0 : 64'(t));
      check($sformatf("t2_dc_data_%0d", t), dc_data_out, 64'(t) << 8);
      tick();
    end
    idle(); #1;
    check("t2_outstanding0", 64'(outstanding), 64'd0);
    check("t2_orphan", 64'(orphan_err), 64'd0);

    // 3: store is not recorded; its tag returning is an orphan
    dc_command = 2'd2; dc_addr = 32'h200; dc_data = 64'h1234_5678_9ABC_DEF0;
    mem2proc_response = 4'd5; #1;
    check("t3_dc_grant", 64'(dc_grant), 64'd1);
    check("t3_cmd", 64'(proc2mem_command), 64'd2);
    check("t3_data", proc2mem_data, 64'h1234_5678_9ABC_DEF0);
    check("t3_dc_resp", 64'(dc_response), 64'd5);
    tick(); idle(); #1;
    check("t3_outstanding", 64'(outstanding), 64'd0);
    mem2proc_tag = 4'd5; #1;
    check("t3_dc_tag", 64'(dc_tag), 64'd0);
    check("t3_ic_tag", 64'(ic_tag), 64'd0);
    tick(); idle(); #1;
    check("t3_orphan", 64'(orphan_err), 64'd1);

    // 4: tag 2 returns to dcache while icache is accepted on tag 2
    dc_command = 2'd1; dc_addr = 32'h300; mem2proc_response = 4'd2; #1;
    check("t4_dc_grant", 64'(dc_grant), 64'd1);
    tick(); idle(); #1;
    check("t4_outstanding_a", 64'(outstanding), 64'd1);
    ic_command = 2'd1; ic_addr = 32'h400; mem2proc_response = 4'd2;
    mem2proc_tag = 4'd2; #1;
    check("t4_ic_grant", 64'(ic_grant), 64'd1);
    check("t4_dc_tag", 64'(dc_tag), 64'd2);
    check("t4_ic_tag", 64'(ic_tag), 64'd0);
    tick(); idle(); #1;
    check("t4_outstanding_b", 64'(outstanding), 64'd1);
    mem2proc_tag = 4'd2; #1;
    check("t4_ic_tag2", 64'(ic_tag), 64'd2);
    check("t4_dc_tag2", 64'(dc_tag), 64'd0);
    tick(); idle(); #1;
    check("t4_outstanding_c", 64'(outstanding), 64'd0);

    // 5: rejected icache load, retried and accepted
    ic_command = 2'd1; ic_addr = 32'h500; mem2proc_response = 4'd0; #1;
    check("t5_ic_grant_rej", 64'(ic_grant), 64'd1);
    check("t5_ic_resp_rej", 64'(ic_response), 64'd0);
    tick(); #1;
    check("t5_outstanding_rej", 64'(outstanding), 64'd0);
    mem2proc_response = 4'd4; #1;
    check("t5_ic_grant_retry", 64'(ic_grant), 64'd1);
    check("t5_ic_resp_retry", 64'(ic_response), 64'd4);
    tick(); idle(); #1;
    check("t5_outstanding", 64'(outstanding), 64'd1);
    mem2proc_tag = 4'd4; #1;
    check("t5_ic_tag", 64'(ic_tag), 64'd4);
    tick(); idle();

    // 6: reset with three loads outstanding
    ic_command = 2'd1; mem2proc_response = 4'd7; tick(); idle();
    dc_command = 2'd1; mem2proc_response = 4'd8; tick(); idle();
    ic_command = 2'd1; mem2proc_response = 4'd9; tick(); idle(); #1;
    check("t6_outstanding3", 64'(outstanding), 64'd3);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("t6_outstanding_rst", 64'(outstanding), 64'd0);
    check("t6_orphan_rst", 64'(orphan_err), 64'd0);
    mem2proc_tag = 4'd8; #1;
    check("t6_dc_tag", 64'(dc_tag), 64'd0);
    check("t6_ic_tag", 64'(ic_tag), 64'd0);
    tick(); idle(); #1;
    check("t6_orphan", 64'(orphan_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
